// File: rtl/tm1637_responder_pkg.sv
// Shared definitions for the TM1637 responder: command classes, command bit
// positions, FSM and frame-tracking encodings.
package tm1637_responder_pkg;

  // Command class lives in bits [7:6] of the first byte after a start.
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // Bit positions inside command bytes.
  localparam int unsigned FIXED_ADDR = 2;
  localparam int unsigned READ       = 1;
  localparam int unsigned DISP_ON    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StAck,
    StRdShift,
    StWaitStop
  } state_e;

  // What the next received byte means within the current frame.
  typedef enum logic [1:0] {
    FrCmd,     // first byte after start: a command
    FrNoData,  // after data/display/unknown command: further bytes are errors
    FrWrite,   // after a valid address command: bytes go to seg[addr]
    FrIgnore   // after an out-of-range address: bytes silently dropped
  } frame_e;

  function automatic logic [1:0] cmd_class(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1637_sync_edge.sv
// Input synchronizer plus edge detector for one TM1637 pin.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized transitions
// The chain resets to 1 so an idle (pulled-up) bus produces no edge after reset.
module tm1637_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = level & ~prev_q;
    fall  = ~level & prev_q;
  end

endmodule

// File: rtl/tm1637_responder.sv
// Device-side end of the TM1637 CLK/DIO link. Decodes start/stop and LSB-first
// bytes, ACKs each byte, and applies data/address/display-control commands to
// a digit register file.
// Ports:
//   clk_50M, rst_n        : system clock, asynchronous active-low reset
//   tm1637_clk/dio        : link clock and wire-level data (async)
//   dio_oe                : 1 = pull DIO low
//   seg_data              : digit registers, digit0 in [7:0]
//   display_on/brightness : display-control state
//   key_code              : key-scan byte returned by a read command
//   byte_strobe/rx_byte   : one-cycle pulse and value of each ACKed byte
//   proto_err             : one-cycle pulse on protocol error
// Build option: define TM1637_KEYREAD_EN to return key_code on read commands;
// otherwise reads are ACKed and DIO stays released (initiator sees 0xFF).
module tm1637_responder
  import tm1637_responder_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    tm1637_clk,
  input  logic                    tm1637_dio,
  output logic                    dio_oe,
  output logic [8*NUM_DIGITS-1:0] seg_data,
  output logic                    display_on,
  output logic [2:0]              brightness,
  input  logic [7:0]              key_code,
  output logic                    byte_strobe,
  output logic [7:0]              rx_byte,
  output logic                    proto_err
);

  localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic clk_lvl, clk_rise, clk_fall;
  logic dio_lvl, dio_rise, dio_fall;

  tm1637_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .pin   (tm1637_clk),
    .level (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  tm1637_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .pin   (tm1637_dio),
    .level (dio_lvl),
    .rise  (dio_rise),
    .fall  (dio_fall)
  );

  // CLK high in both previous and current sample; a simultaneous CLK edge
  // therefore masks start/stop.
  logic clk_held, start_cond, stop_cond;
  assign clk_held   = clk_lvl & ~clk_rise;
  assign start_cond = clk_held & dio_fall;
  assign stop_cond  = clk_held & dio_rise;

  logic [7:0] key_src;
`ifdef TM1637_KEYREAD_EN
  assign key_src = key_code;
`else
  logic unused_key;
  assign unused_key = ^key_code;
  assign key_src    = 8'hFF;
`endif

  state_e                    state_q, state_d;
  frame_e                    frame_q, frame_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      pend_q, pend_d;   // a rise was sampled, its fall not yet seen
  logic [6:0]                shreg_q, shreg_d;
  logic                      ack_seen_q, ack_seen_d;
  logic                      drive_q, drive_d;
  logic [3:0]                rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      auto_inc_q, auto_inc_d;
  logic                      read_mode_q, read_mode_d;
  logic [NUM_DIGITS-1:0][7:0] seg_q, seg_d;
  logic                      disp_on_q, disp_on_d;
  logic [2:0]                bright_q, bright_d;
  logic                      strobe_q, strobe_d;
  logic [7:0]                rx_q, rx_d;
  logic                      err_q, err_d;
  logic [7:0]                byte_in;

  // Completed byte at the 8th rise: bit 7 is the current DIO sample.
  assign byte_in = {dio_lvl, shreg_q};

  // State register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= FrCmd;
      bit_cnt_q   <= '0;
      pend_q      <= 1'b0;
      shreg_q     <= '0;
      ack_seen_q  <= 1'b0;
      drive_q     <= 1'b0;
      rd_cnt_q    <= '0;
      addr_q      <= '0;
      auto_inc_q  <= 1'b1;
      read_mode_q <= 1'b0;
      seg_q       <= '0;
      disp_on_q   <= 1'b0;
      bright_q    <= '0;
      strobe_q    <= 1'b0;
      rx_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      shreg_q     <= shreg_d;
      ack_seen_q  <= ack_seen_d;
      drive_q     <= drive_d;
      rd_cnt_q    <= rd_cnt_d;
      addr_q      <= addr_d;
      auto_inc_q  <= auto_inc_d;
      read_mode_q <= read_mode_d;
      seg_q       <= seg_d;
      disp_on_q   <= disp_on_d;
      bright_q    <= bright_d;
      strobe_q    <= strobe_d;
      rx_q        <= rx_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    pend_d      = pend_q;
    shreg_d     = shreg_q;
    ack_seen_d  = ack_seen_q;
    drive_d     = drive_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    auto_inc_d  = auto_inc_q;
    read_mode_d = read_mode_q;
    seg_d       = seg_q;
    disp_on_d   = disp_on_q;
    bright_d    = bright_q;
    strobe_d    = 1'b0;
    rx_d        = rx_q;
    err_d       = 1'b0;

    if (start_cond || stop_cond) begin
      // A lone pending rise with no committed bits is the clock that precedes
      // a stop or repeated start, not a partial byte.
      if (state_q == StShift && bit_cnt_q != 3'd0) err_d = 1'b1;
      drive_d    = 1'b0;
      bit_cnt_d  = '0;
      pend_d     = 1'b0;
      ack_seen_d = 1'b0;
      if (start_cond) begin
        state_d     = StShift;
        frame_d     = FrCmd;
        read_mode_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end else begin
      case (state_q)
        StShift: begin
          if (clk_rise) begin
            if (bit_cnt_q == 3'd7) begin
              state_d    = StAck;
              bit_cnt_d  = '0;
              pend_d     = 1'b0;
              ack_seen_d = 1'b0;
              strobe_d   = 1'b1;
              rx_d       = byte_in;
              case (frame_q)
                FrCmd: begin
                  case (cmd_class(byte_in))
                    CMD_DATA: begin
                      auto_inc_d = ~byte_in[FIXED_ADDR];
`ifdef TM1637_KEYREAD_EN
                      read_mode_d = byte_in[READ];
`endif
                      frame_d = FrNoData;
                    end
                    CMD_DISP: begin
                      disp_on_d = byte_in[DISP_ON];
                      bright_d  = byte_in[2:0];
                      frame_d   = FrNoData;
                    end
                    CMD_ADDR: begin
                      if (32'(byte_in[3:0]) < NUM_DIGITS) begin
                        addr_d  = AW'(byte_in[3:0]);
                        frame_d = FrWrite;
                      end else begin
                        err_d   = 1'b1;
                        frame_d = FrIgnore;
                      end
                    end
                    default: begin
                      err_d   = 1'b1;
                      frame_d = FrNoData;
                    end
                  endcase
                end
                FrWrite: begin
                  seg_d[addr_q] = byte_in;
                  if (auto_inc_q) begin
                    addr_d = (32'(addr_q) == NUM_DIGITS - 1) ? '0 : addr_q + AW'(1);
                  end
                end
                FrIgnore: ;
                default: err_d = 1'b1;
              endcase
            end else begin
              shreg_d[bit_cnt_q] = dio_lvl;
              pend_d             = 1'b1;
            end
          end else if (clk_fall && pend_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            pend_d    = 1'b0;
          end
        end
        StAck: begin
          if (clk_fall) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else if (ack_seen_q) begin
              // Fall after the 9th rise: release, or put read bit 0 out.
              if (read_mode_q) begin
                drive_d  = ~key_src[0];
                rd_cnt_d = 4'd1;
                state_d  = StRdShift;
              end else begin
                drive_d = 1'b0;
                state_d = StShift;
              end
            end
          end else if (clk_rise && drive_q) begin
            ack_seen_d = 1'b1;
          end
        end
        StRdShift: begin
          if (clk_fall) begin
            if (rd_cnt_q == 4'd8) begin
              drive_d = 1'b0;
              state_d = StWaitStop;
            end else begin
              drive_d  = ~key_src[rd_cnt_q[2:0]];
              rd_cnt_d = rd_cnt_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    dio_oe      = drive_q;
    seg_data    = seg_q;
    display_on  = disp_on_q;
    brightness  = bright_q;
    byte_strobe = strobe_q;
    rx_byte     = rx_q;
    proto_err   = err_q;
  end

endmodule

// File: tb/tb_tm1637_responder.sv
module tb_tm1637_responder;

  localparam int H = 160;  // link quarter-period in ns (8 system clocks)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_clk = 1'b1;
  logic        init_dio = 1'b1;
  logic        tm1637_dio;
  logic        dio_oe;
  logic [47:0] seg_data;
  logic        display_on;
  logic [2:0]  brightness;
  logic [7:0]  key_code = 8'hF5;
  logic        byte_strobe;
  logic [7:0]  rx_byte;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_strobe = 0;
  int cnt_err    = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  // Open-drain wire: either side can pull low.
  assign tm1637_dio = init_dio & ~dio_oe;

  tm1637_responder #(.NUM_DIGITS(6), .SYNC_STAGES(2)) dut (
    .clk_50M     (clk),
    .rst_n       (rst_n),
    .tm1637_clk  (init_clk),
    .tm1637_dio  (tm1637_dio),
    .dio_oe      (dio_oe),
    .seg_data    (seg_data),
    .display_on  (display_on),
    .brightness  (brightness),
    .key_code    (key_code),
    .byte_strobe (byte_strobe),
    .rx_byte     (rx_byte),
    .proto_err   (proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ACKed byte must match the next byte the initiator sent.
  always @(negedge clk) begin
    if (byte_strobe) begin
      cnt_strobe++;
      if (exp_q.size() == 0) check("rx_unexpected", {56'd0, rx_byte}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("rx_byte", {56'd0, rx_byte}, {56'd0, exp_q.pop_front()});
    end
    if (proto_err) cnt_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_start();
    init_dio = 1'b1; init_clk = 1'b1; #H;
    init_dio = 1'b0; #H;
    init_clk = 1'b0; #H;
  endtask

  task automatic bus_stop();
    init_clk = 1'b0; #H;
    init_dio = 1'b0; #H;
    init_clk = 1'b1; #H;
    init_dio = 1'b1; #H;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      init_clk = 1'b0; #H;
      init_dio = b[i]; #H;
      init_clk = 1'b1; #(2*H);
    end
  endtask

  // 9th clock: responder must hold DIO low exactly across it.
  task automatic ack_clock(input logic chk_rel);
    check("ack_pre_oe", {63'd0, dio_oe}, 64'd0);
    init_clk = 1'b0; #H;
    init_dio = 1'b1; #H;
    init_clk = 1'b1; #H;
    check("ack_oe", {63'd0, dio_oe}, 64'd1);
    check("ack_wire", {63'd0, tm1637_dio}, 64'd0);
    #H;
    init_clk = 1'b0; #H;
    if (chk_rel) check("ack_release", {63'd0, dio_oe}, 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic chk_rel);
    exp_q.push_back(b);
    send_bits(b, 8);
    ack_clock(chk_rel);
  endtask

  typedef struct {
    int          n;
    logic [63:0] b;     // byte i in [8*i +: 8]
    logic [47:0] seg;
    logic        on;
    logic [2:0]  br;
    int          err;
  } row_t;

  row_t rows [12];

  initial begin
    logic [63:0] bb;
    logic [7:0]  rd;
    int          s0, e0;

    rows[0]  = '{1, 64'h8F,               48'h0,            1'b1, 3'd7, 0};
    rows[1]  = '{1, 64'h40,               48'h0,            1'b1, 3'd7, 0};
    rows[2]  = '{8, 64'h7D6D664F5B063FC0, 48'h6D664F5B067D, 1'b1, 3'd7, 0};
    rows[3]  = '{1, 64'h44,               48'h6D664F5B067D, 1'b1, 3'd7, 0};
    rows[4]  = '{3, 64'h4F5BC3,           48'h6D664F5B067D, 1'b1, 3'd7, 0};
    rows[5]  = '{1, 64'hC7,               48'h6D664F5B067D, 1'b1, 3'd7, 1};
    rows[6]  = '{1, 64'h12,               48'h6D664F5B067D, 1'b1, 3'd7, 1};
    rows[7]  = '{2, 64'h1140,             48'h6D664F5B067D, 1'b1, 3'd7, 1};
    rows[8]  = '{3, 64'hBBAAC5,           48'hAA664F5B06BB, 1'b1, 3'd7, 0};
    rows[9]  = '{1, 64'h80,               48'hAA664F5B06BB, 1'b0, 3'd0, 0};
    rows[10] = '{1, 64'h8A,               48'hAA664F5B06BB, 1'b1, 3'd2, 0};
    rows[11] = '{2, 64'h10C6,             48'hAA664F5B06BB, 1'b1, 3'd2, 1};

    // Reset state
    #25;
    check("rst_oe", {63'd0, dio_oe}, 64'd0);
    check("rst_seg", {16'd0, seg_data}, 64'd0);
    check("rst_disp", {60'd0, display_on, brightness}, 64'd0);
    check("rst_strobe_err", {62'd0, byte_strobe, proto_err}, 64'd0);
    check("rst_rx", {56'd0, rx_byte}, 64'd0);
    @(negedge clk); rst_n = 1'b1; #H;

    for (int r = 0; r < 12; r++) begin
      s0 = cnt_strobe; e0 = cnt_err;
      bb = rows[r].b;
      bus_start();
      for (int i = 0; i < rows[r].n; i++) send_byte(bb[8*i +: 8], 1'b1);
      bus_stop();
      #H;
      check($sformatf("row%0d_seg", r), {16'd0, seg_data}, {16'd0, rows[r].seg});
      check($sformatf("row%0d_on", r), {63'd0, display_on}, {63'd0, rows[r].on});
      check($sformatf("row%0d_br", r), {61'd0, brightness}, {61'd0, rows[r].br});
      check($sformatf("row%0d_err", r), 64'(cnt_err - e0), 64'(rows[r].err));
      check($sformatf("row%0d_strobes", r), 64'(cnt_strobe - s0), 64'(rows[r].n));
    end

    // Stop after 4 bits: error, nothing applied
    s0 = cnt_strobe; e0 = cnt_err;
    bus_start();
    send_bits(8'h8F, 4);
    bus_stop();
    #H;
    check("abort_err", 64'(cnt_err - e0), 64'd1);
    check("abort_strobes", 64'(cnt_strobe - s0), 64'd0);
    check("abort_seg", {16'd0, seg_data}, 64'hAA664F5B06BB);
    check("abort_disp", {60'd0, display_on, brightness}, {60'd0, 1'b1, 3'd2});

    // Partial byte then restart: error, new frame still decoded
    s0 = cnt_strobe; e0 = cnt_err;
    bus_start();
    send_bits(8'h00, 3);
    bus_start();
    send_byte(8'h80, 1'b1);
    bus_stop();
    #H;
    check("restart_err", 64'(cnt_err - e0), 64'd1);
    check("restart_strobes", 64'(cnt_strobe - s0), 64'd1);
    check("restart_disp", {63'd0, display_on}, 64'd0);

    // Read command
    bus_start();
    send_byte(8'h42, 1'b0);
`ifndef TM1637_KEYREAD_EN
    exp_q.push_back(8'hFF);
`endif
    rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      init_clk = 1'b0; #(2*H);
      init_clk = 1'b1; #H;
      rd[i] = tm1637_dio; #H;
    end
    init_clk = 1'b0; #(2*H);
    init_clk = 1'b1; #(2*H);
    bus_stop();
    #H;
`ifdef TM1637_KEYREAD_EN
    check("read_key", {56'd0, rd}, 64'hF5);
`else
    check("read_key", {56'd0, rd}, 64'hFF);
`endif
    check("read_oe_idle", {63'd0, dio_oe}, 64'd0);

    // Reset while ACK is being driven
    bus_start();
    exp_q.push_back(8'h8F);
    send_bits(8'h8F, 8);
    init_clk = 1'b0; #H;
    init_dio = 1'b1; #H;
    check("rstack_pre_oe", {63'd0, dio_oe}, 64'd1);
    check("rstack_pre_on", {63'd0, display_on}, 64'd1);
    rst_n = 1'b0; #1;
    check("rstack_oe", {63'd0, dio_oe}, 64'd0);
    check("rstack_seg", {16'd0, seg_data}, 64'd0);
    check("rstack_disp", {60'd0, display_on, brightness}, 64'd0);
    check("rstack_rx", {56'd0, rx_byte}, 64'd0);
    init_clk = 1'b1; init_dio = 1'b1;
    #H; @(negedge clk); rst_n = 1'b1; #H;

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
